// File: rtl/timer_dev.sv
// Memory-mapped interval timer: CTRL/PRESET/COUNT registers, down-counter FSM
// with one-shot or auto-reload modes and a maskable, registered interrupt.
module timer_dev (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic [3:0]  i_byteen,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  // state  | meaning
  // IDLE   | waiting for EN
  // LOAD   | COUNT <- PRESET
  // CNT    | counting down toward terminal count
  // INT    | terminal count reached, decide reload or stop
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic        r_irq;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_auto;
  logic        w_flag_set;
  logic [3:0]  w_ctrl_nxt;
  logic        w_flag_nxt;

  assign w_wr_ctrl   = i_sel & i_we & (i_addr == 2'd0);
  assign w_wr_preset = i_sel & i_we & (i_addr == 2'd1);
  assign w_auto      = (r_ctrl[2:1] == 2'b01);
  assign w_flag_set  = (r_state == S_CNT) & r_ctrl[0] & (r_count <= 32'd1);

  // Software CTRL write overrides the FSM's EN clear on the same edge.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if ((r_state == S_INT) && !w_auto)
      w_ctrl_nxt[0] = 1'b0;
    if (w_wr_ctrl && i_byteen[0])
      w_ctrl_nxt = i_wdata[3:0];
  end

  // Register writes clear the flag even when terminal count hits the same edge.
  always_comb begin
    w_flag_nxt = r_irq_flag;
    if (w_wr_ctrl || w_wr_preset)
      w_flag_nxt = 1'b0;
    else if (w_flag_set)
      w_flag_nxt = 1'b1;
    else if ((r_state == S_INT) && w_auto)
      w_flag_nxt = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl     <= 4'd0;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
      r_preset   <= 32'd0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_irq_flag <= w_flag_nxt;
      r_irq      <= w_flag_nxt & w_ctrl_nxt[3];
      for (int i = 0; i < 4; i++) begin
        if (w_wr_preset && i_byteen[i])
          r_preset[8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (r_ctrl[0]) r_state <= S_LOAD;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count <= 32'd0;
            r_state <= S_INT;
          end
        end
        S_INT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      2'd0:    o_rdata = {28'd0, r_ctrl};
      2'd1:    o_rdata = r_preset;
      2'd2:    o_rdata = r_count;
      default: o_rdata = 32'd0;
    endcase
  end

  assign o_irq = r_irq;

endmodule
